// File: rtl/ringbuf_conv_sequencer.sv
// Control FSM for the sample ring buffer: head pointer, sample writes, convolution passes.
// Define RINGSEQ_CFG_CHECK_EN to add the registered illegal-bounds check on o_cfg_err.
module ringbuf_conv_sequencer #(
   parameter int unsigned DATA_ADDRESS_WIDTH = 12,
   parameter int unsigned DATA_OFFSET_WIDTH  = 10,
   parameter int unsigned COEF_ADDRESS_WIDTH = 10
) (
   input  logic                          i_clk,
   input  logic                          i_clr_n,
   input  logic                          i_sw_clr,
   input  logic [DATA_ADDRESS_WIDTH-1:0] i_cfg_uptr,
   input  logic [DATA_ADDRESS_WIDTH-1:0] i_cfg_lptr,
   input  logic                          i_wr_req,
   output logic                          o_wr_ack,
   input  logic                          i_conv_req,
   output logic                          o_conv_done,
   output logic                          o_busy,
   output logic                          o_rb_clr,
   output logic                          o_rb_init,
   output logic                          o_rb_cnt,
   output logic [DATA_OFFSET_WIDTH-1:0]  o_rb_head_offset,
   input  logic                          i_rb_count_fin,
   output logic                          o_ram_we,
   output logic [DATA_ADDRESS_WIDTH-1:0] o_ram_wr_addr,
   output logic                          o_ram_re,
   output logic [COEF_ADDRESS_WIDTH-1:0] o_coef_addr,
   output logic                          o_mac_clr,
   output logic                          o_mac_en,
   output logic                          o_mac_last,
   output logic                          o_cfg_err
);

   typedef enum logic [2:0] {StIdle, StWrite, StInit, StRun, StDrain, StDone} state_e;

   state_e                          r_state;
   logic [DATA_OFFSET_WIDTH-1:0]    r_head;
   logic [DATA_ADDRESS_WIDTH-1:0]   r_wr_addr;
   logic [COEF_ADDRESS_WIDTH-1:0]   r_coef;
   logic                            r_wr_ack;
   logic                            r_ram_we;
   logic                            r_rb_init;
   logic                            r_ram_re;
   logic                            r_mac_clr;
   logic                            r_mac_en;
   logic                            r_conv_done;
   logic                            r_sw_clr;

   logic [DATA_ADDRESS_WIDTH-1:0]   w_span;
   logic [DATA_OFFSET_WIDTH-1:0]    w_nxt;
   logic                            w_cfg_bad;
   logic                            w_req_ok;

   assign w_span = i_cfg_lptr - i_cfg_uptr;
   assign w_nxt  = (DATA_ADDRESS_WIDTH'(r_head) == w_span) ? '0
                                                           : r_head + DATA_OFFSET_WIDTH'(1);

`ifdef RINGSEQ_CFG_CHECK_EN
   logic r_cfg_err;

   assign w_cfg_bad = (i_cfg_lptr < i_cfg_uptr) ||
                      (w_span > DATA_ADDRESS_WIDTH'((2 ** DATA_OFFSET_WIDTH) - 1));

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_cfg_err <= 1'b0;
      end else if (r_state == StIdle) begin
         r_cfg_err <= w_cfg_bad;
      end
   end

   assign o_cfg_err = r_cfg_err;
`else
   assign w_cfg_bad = 1'b0;
   assign o_cfg_err = 1'b0;
`endif

   // Gate on the live check too, so a bad config is never accepted before the flag registers.
   assign w_req_ok = !w_cfg_bad && !o_cfg_err;

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_state     <= StIdle;
         r_head      <= '0;
         r_wr_addr   <= '0;
         r_coef      <= '0;
         r_wr_ack    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_rb_init   <= 1'b0;
         r_ram_re    <= 1'b0;
         r_mac_clr   <= 1'b0;
         r_mac_en    <= 1'b0;
         r_conv_done <= 1'b0;
         r_sw_clr    <= 1'b0;
      end else begin
         r_sw_clr    <= i_sw_clr;
         r_mac_en    <= o_ram_re;
         r_wr_ack    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_rb_init   <= 1'b0;
         r_mac_clr   <= 1'b0;
         r_conv_done <= 1'b0;
         if (i_sw_clr) begin
            r_state  <= StIdle;
            r_head   <= '0;
            r_coef   <= '0;
            r_ram_re <= 1'b0;
         end else begin
            unique case (r_state)
               StIdle: begin
                  if (w_req_ok && i_wr_req) begin
                     r_state   <= StWrite;
                     r_wr_ack  <= 1'b1;
                     r_ram_we  <= 1'b1;
                     r_wr_addr <= i_cfg_uptr + DATA_ADDRESS_WIDTH'(w_nxt);
                  end else if (w_req_ok && i_conv_req) begin
                     r_state   <= StInit;
                     r_rb_init <= 1'b1;
                     r_mac_clr <= 1'b1;
                     r_coef    <= '0;
                  end
               end
               StWrite: begin
                  r_head  <= w_nxt;
                  r_state <= StIdle;
               end
               StInit: begin
                  r_state  <= StRun;
                  r_ram_re <= 1'b1;
               end
               StRun: begin
                  if (i_rb_count_fin) begin
                     r_state  <= StDrain;
                     r_ram_re <= 1'b0;
                  end else begin
                     r_coef <= r_coef + COEF_ADDRESS_WIDTH'(1);
                  end
               end
               StDrain: begin
                  r_state     <= StDone;
                  r_conv_done <= 1'b1;
               end
               StDone:  r_state <= StIdle;
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   // Strobes are masked by sw_clr in the cycle it is asserted; rb_cnt follows the live last-tap flag.
   assign o_busy           = (r_state != StIdle);
   assign o_rb_clr         = i_sw_clr | r_sw_clr;
   assign o_wr_ack         = r_wr_ack & ~i_sw_clr;
   assign o_ram_we         = r_ram_we & ~i_sw_clr;
   assign o_rb_init        = r_rb_init & ~i_sw_clr;
   assign o_mac_clr        = r_mac_clr & ~i_sw_clr;
   assign o_ram_re         = r_ram_re & ~i_sw_clr;
   assign o_mac_en         = r_mac_en & ~i_sw_clr;
   assign o_mac_last       = o_mac_en & (r_state == StDrain);
   assign o_conv_done      = r_conv_done & ~i_sw_clr;
   assign o_rb_cnt         = (r_state == StRun) & ~i_rb_count_fin & ~i_sw_clr;
   assign o_rb_head_offset = r_head;
   assign o_ram_wr_addr    = r_wr_addr;
   assign o_coef_addr      = r_coef;

endmodule
